multicycle_cpu: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle RV32I core.
- Executes one instruction over four clock states: FETCH, DECODE, EXECUTE, WRITEBACK.
- Adds I-type logic/shift ops, BEQ/BNE branches, a halt state, a retired-instruction counter and configurable memory/reset parameters.
- Instruction ROM is loaded through a port array, the same way as in the existing core's benches.

---
 rtl/multicycle_cpu.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: four-state (FETCH/DECODE/EXECUTE/WRITEBACK) RV32I subset core
// with a sticky HALT, a retired-instruction counter and a port-loaded instruction ROM.
module multicycle_cpu #(
  parameter int          IMEM_DEPTH    = 32,
  parameter logic [31:0] RESET_PC      = 32'd0,
  parameter int          REG_INIT_BASE = 3000,
  parameter int          CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          initial_instructions [IMEM_DEPTH],
  output logic [31:0]          pc_out_check,
  output logic [31:0]          instruction_check,
  output logic [1:0]           state_check,
  output logic [31:0]          alu_result_check,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired_count
);
  localparam int          AW         = $clog2(IMEM_DEPTH);
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_DEPTH * 4);

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_DECODE = 2'd1, S_EXEC = 2'd2, S_WB = 2'd3} state_t;
  typedef enum logic [2:0] {OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                            OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_SLT = 3'd7} alu_op_t;

  state_t               r_state, w_state_nxt;
  logic                 r_halted, w_halted_nxt;
  logic [31:0]          r_pc, r_ir, r_a, r_b, r_imm, r_alu;
  alu_op_t              r_op, w_op;
  logic                 r_use_imm, r_branch, r_bne, r_wr_en;
  logic                 w_use_imm, w_branch, w_bne, w_wr_en, w_valid;
  logic [31:0]          w_imm, w_rs1_val, w_rs2_val, w_opb, w_alu, w_pc_nxt;
  logic                 w_taken, w_wb_halt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [31:0]          r_regs [0:31];

  logic [6:0] w_opcode, w_funct7;
  logic [2:0] w_funct3;
  logic [4:0] w_rs1, w_rs2, w_rd;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_funct3 = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_funct7 = r_ir[31:25];

  // x0 is hard-wired to zero on the read side
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

  // Instruction decode from IR: ALU op, operand select, immediate, legality
  always_comb begin
    w_op      = OP_ADD;
    w_use_imm = 1'b0;
    w_branch  = 1'b0;
    w_bne     = 1'b0;
    w_wr_en   = 1'b0;
    w_valid   = 1'b0;
    w_imm     = {{20{r_ir[31]}}, r_ir[31:20]};
    case (w_opcode)
      7'b0110011: begin
        w_wr_en = 1'b1;
        w_valid = 1'b1;
        if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) w_op = OP_SUB;
        else if (w_funct7 == 7'b0000000) begin
          case (w_funct3)
            3'b000:  w_op = OP_ADD;
            3'b001:  w_op = OP_SLL;
            3'b010:  w_op = OP_SLT;
            3'b100:  w_op = OP_XOR;
            3'b101:  w_op = OP_SRL;
            3'b110:  w_op = OP_OR;
            3'b111:  w_op = OP_AND;
            default: w_valid = 1'b0;
          endcase
        end else w_valid = 1'b0;
      end
      7'b0010011: begin
        w_wr_en   = 1'b1;
        w_use_imm = 1'b1;
        w_valid   = 1'b1;
        case (w_funct3)
          3'b000:  w_op = OP_ADD;
          3'b010:  w_op = OP_SLT;
          3'b100:  w_op = OP_XOR;
          3'b110:  w_op = OP_OR;
          3'b111:  w_op = OP_AND;
          // shift-immediates require funct7==0 (SRAI is not supported)
          3'b001:  begin w_op = OP_SLL; w_valid = (w_funct7 == 7'd0); end
          3'b101:  begin w_op = OP_SRL; w_valid = (w_funct7 == 7'd0); end
          default: w_valid = 1'b0;
        endcase
      end
      7'b1100011: begin
        w_imm    = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
        w_op     = OP_SUB;
        w_branch = 1'b1;
        w_bne    = (w_funct3 == 3'b001);
        w_valid  = (w_funct3 == 3'b000) || (w_funct3 == 3'b001);
      end
      default: ;
    endcase
    if (r_ir == 32'd0) w_valid = 1'b0;
  end

  // ALU on the operands latched in DECODE
  always_comb begin
    w_opb = r_use_imm ? r_imm : r_b;
    w_alu = 32'd0;
    case (r_op)
      OP_ADD:  w_alu = r_a + w_opb;
      OP_SUB:  w_alu = r_a - w_opb;
      OP_AND:  w_alu = r_a & w_opb;
      OP_OR:   w_alu = r_a | w_opb;
      OP_XOR:  w_alu = r_a ^ w_opb;
      OP_SLL:  w_alu = r_a << w_opb[4:0];
      OP_SRL:  w_alu = r_a >> w_opb[4:0];
      OP_SLT:  w_alu = {31'd0, $signed(r_a) < $signed(w_opb)};
      default: w_alu = 32'd0;
    endcase
  end

  // Writeback PC: branch resolution from the SUB result, plus out-of-range/misaligned halt
  always_comb begin
    w_taken   = r_branch && (r_bne ? (r_alu != 32'd0) : (r_alu == 32'd0));
    w_pc_nxt  = w_taken ? (r_pc + r_imm) : (r_pc + 32'd4);
    w_wb_halt = (w_pc_nxt >= IMEM_BYTES) || (w_taken && (w_pc_nxt[1:0] != 2'b00));
  end

  // Next-state logic; HALT freezes the state code of whichever state entered it
  always_comb begin
    w_state_nxt  = r_state;
    w_halted_nxt = r_halted;
    if (!r_halted) begin
      case (r_state)
        S_FETCH:  w_state_nxt = S_DECODE;
        S_DECODE: if (w_valid) w_state_nxt = S_EXEC; else w_halted_nxt = 1'b1;
        S_EXEC:   w_state_nxt = S_WB;
        S_WB:     if (w_wb_halt) w_halted_nxt = 1'b1; else w_state_nxt = S_FETCH;
        default:  w_state_nxt = S_FETCH;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_FETCH;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // Datapath registers: IR, operand latches, ALU result, PC, retired counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_imm     <= 32'd0;
      r_alu     <= 32'd0;
      r_op      <= OP_ADD;
      r_use_imm <= 1'b0;
      r_branch  <= 1'b0;
      r_bne     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_cnt     <= '0;
    end else if (!r_halted) begin
      case (r_state)
        S_FETCH: r_ir <= initial_instructions[r_pc[AW+1:2]];
        S_DECODE: begin
          r_a       <= w_rs1_val;
          r_b       <= w_rs2_val;
          r_imm     <= w_imm;
          r_op      <= w_op;
          r_use_imm <= w_use_imm;
          r_branch  <= w_branch;
          r_bne     <= w_bne;
          r_wr_en   <= w_wr_en;
        end
        S_EXEC: r_alu <= w_alu;
        S_WB: begin
          r_pc  <= w_pc_nxt;
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Register file: reset to REG_INIT_BASE+i, written only in WRITEBACK
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= (i == 0) ? 32'd0 : 32'(REG_INIT_BASE + i);
    end else if (!r_halted && r_state == S_WB && r_wr_en && w_rd != 5'd0) begin
      r_regs[w_rd] <= r_alu;
    end
  end

  assign pc_out_check      = r_pc;
  assign instruction_check = r_ir;
  assign state_check       = r_state;
  assign alu_result_check  = r_alu;
  assign halted            = r_halted;
  assign retired_count     = r_cnt;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed vector tables plus hand-written multi-cycle sequences.
module tb_multicycle_cpu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset4;
  logic [31:0] rom  [32];
  logic [31:0] rom4 [4];
  logic [31:0] pc, ir, alu, pc4, ir4, alu4;
  logic [1:0]  st, st4;
  logic        hlt, hlt4;
  logic [15:0] cnt, cnt4;

  multicycle_cpu dut (
    .clk(clk), .reset(reset), .initial_instructions(rom),
    .pc_out_check(pc), .instruction_check(ir), .state_check(st),
    .alu_result_check(alu), .halted(hlt), .retired_count(cnt));

  multicycle_cpu #(.IMEM_DEPTH(4), .RESET_PC(32'd8)) dut4 (
    .clk(clk), .reset(reset4), .initial_instructions(rom4),
    .pc_out_check(pc4), .instruction_check(ir4), .state_check(st4),
    .alu_result_check(alu4), .halted(hlt4), .retired_count(cnt4));

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] pc;
    logic [1:0]  st;
    logic        hlt;
    logic [15:0] cnt;
    logic [31:0] alu;
    int          ridx;
    logic [31:0] rv;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input int c, input logic [31:0] p, input logic [1:0] s,
                     input logic h, input logic [15:0] n, input logic [31:0] a,
                     input int ri, input logic [31:0] r);
    vec_t v;
    v.name = nm; v.cyc = c; v.pc = p; v.st = s; v.hlt = h; v.cnt = n; v.alu = a;
    v.ridx = ri; v.rv = r;
    vq.push_back(v);
  endtask

  // Run the queued vectors against dut: advance cyc cycles, then compare every field
  task automatic apply_vectors();
    foreach (vq[k]) begin
      repeat (vq[k].cyc) @(negedge clk);
      check({vq[k].name, ".pc"},     pc,                 vq[k].pc);
      check({vq[k].name, ".state"},  32'(st),            32'(vq[k].st));
      check({vq[k].name, ".halted"}, 32'(hlt),           32'(vq[k].hlt));
      check({vq[k].name, ".retired"},32'(cnt),           32'(vq[k].cnt));
      check({vq[k].name, ".alu"},    alu,                vq[k].alu);
      check({vq[k].name, ".reg"},    dut.r_regs[vq[k].ridx], vq[k].rv);
    end
    vq.delete();
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 32'd0;
  endtask

  // Leaves the bench at a negedge with reset released; next posedge is FETCH
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset  = 1'b0;
    reset4 = 1'b0;
    clear_rom();
    foreach (rom4[i]) rom4[i] = 32'd0;

    // Program 1: add / sub / addi, then halt on a zero word
    rom[0] = enc_r(7'h00, 5'd5, 5'd6, 3'b000, 5'd7);
    rom[1] = enc_r(7'h20, 5'd8, 5'd9, 3'b000, 5'd10);
    rom[2] = enc_i(12'd1, 5'd12, 3'b000, 5'd13);
    do_reset();
    add("p1_reset", 0, 32'd0,  2'd0, 1'b0, 16'd0, 32'd0,    7,  32'd3007);
    add("p1_fetch", 1, 32'd0,  2'd1, 1'b0, 16'd0, 32'd0,    7,  32'd3007);
    add("p1_add",   3, 32'd4,  2'd0, 1'b0, 16'd1, 32'd6011, 7,  32'd6011);
    add("p1_sub",   4, 32'd8,  2'd0, 1'b0, 16'd2, 32'd1,    10, 32'd1);
    add("p1_addi",  4, 32'd12, 2'd0, 1'b0, 16'd3, 32'd3013, 13, 32'd3013);
    add("p1_halt",  2, 32'd12, 2'd1, 1'b1, 16'd3, 32'd3013, 13, 32'd3013);
    add("p1_stay",  6, 32'd12, 2'd1, 1'b1, 16'd3, 32'd3013, 7,  32'd6011);
    apply_vectors();

    // Program 2a: taken BEQ skips the addi to x2
    clear_rom();
    rom[0] = enc_b(13'd8, 5'd1, 5'd1, 3'b000);
    rom[1] = enc_i(12'd5, 5'd0, 3'b000, 5'd2);
    rom[2] = enc_i(12'd7, 5'd0, 3'b000, 5'd3);
    do_reset();
    add("beq_rst",  0, 32'd0,  2'd0, 1'b0, 16'd0, 32'd0, 2, 32'd3002);
    add("beq_br",   4, 32'd8,  2'd0, 1'b0, 16'd1, 32'd0, 2, 32'd3002);
    add("beq_x3",   4, 32'd12, 2'd0, 1'b0, 16'd2, 32'd7, 3, 32'd7);
    add("beq_halt", 2, 32'd12, 2'd1, 1'b1, 16'd2, 32'd7, 2, 32'd3002);
    apply_vectors();

    // Program 2b: BNE on equal operands falls through
    rom[0] = enc_b(13'd8, 5'd1, 5'd1, 3'b001);
    do_reset();
    add("bne_br",   4, 32'd4,  2'd0, 1'b0, 16'd1, 32'd0, 2, 32'd3002);
    add("bne_x2",   4, 32'd8,  2'd0, 1'b0, 16'd2, 32'd5, 2, 32'd5);
    add("bne_x3",   4, 32'd12, 2'd0, 1'b0, 16'd3, 32'd7, 3, 32'd7);
    add("bne_halt", 2, 32'd12, 2'd1, 1'b1, 16'd3, 32'd7, 2, 32'd5);
    apply_vectors();

    // Program 3: x0 write discarded, xori/slti/srli
    clear_rom();
    rom[0] = enc_i(12'd9,   5'd0, 3'b000, 5'd0);
    rom[1] = enc_i(12'hFFF, 5'd4, 3'b100, 5'd4);
    rom[2] = enc_i(12'd0,   5'd4, 3'b010, 5'd5);
    rom[3] = enc_i(12'd28,  5'd4, 3'b101, 5'd6);
    do_reset();
    add("addi_x0", 4, 32'd4,  2'd0, 1'b0, 16'd1, 32'd9,         0, 32'd0);
    add("xori",    4, 32'd8,  2'd0, 1'b0, 16'd2, 32'hFFFFF443,  4, 32'hFFFFF443);
    add("slti",    4, 32'd12, 2'd0, 1'b0, 16'd3, 32'd1,         5, 32'd1);
    add("srli",    4, 32'd16, 2'd0, 1'b0, 16'd4, 32'd15,        6, 32'd15);
    add("p3_halt", 2, 32'd16, 2'd1, 1'b1, 16'd4, 32'd15,        0, 32'd0);
    apply_vectors();

    // Reset asserted during EXECUTE of the second instruction of program 1
    clear_rom();
    rom[0] = enc_r(7'h00, 5'd5, 5'd6, 3'b000, 5'd7);
    rom[1] = enc_r(7'h20, 5'd8, 5'd9, 3'b000, 5'd10);
    rom[2] = enc_i(12'd1, 5'd12, 3'b000, 5'd13);
    do_reset();
    repeat (6) @(negedge clk);
    check("midrst.in_exec", 32'(st), 32'd2);
    reset = 1'b0;
    @(negedge clk);
    check("midrst.pc",      pc,            32'd0);
    check("midrst.state",   32'(st),       32'd0);
    check("midrst.retired", 32'(cnt),      32'd0);
    check("midrst.x10",     dut.r_regs[10], 32'd3010);
    check("midrst.x7",      dut.r_regs[7],  32'd3007);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst.rerun_x10", dut.r_regs[10], 32'd1);
    check("midrst.rerun_cnt", 32'(cnt),       32'd2);

    // Unsupported opcode halts in DECODE without retiring
    clear_rom();
    rom[0] = enc_i(12'd1, 5'd1, 3'b000, 5'd1);
    rom[1] = 32'h0000007F;
    do_reset();
    repeat (6) @(negedge clk);
    check("badop.halted",  32'(hlt), 32'd1);
    check("badop.state",   32'(st),  32'd1);
    check("badop.retired", 32'(cnt), 32'd1);
    check("badop.pc",      pc,       32'd4);

    // Taken branch to a non-word-aligned target halts in WRITEBACK
    clear_rom();
    rom[0] = enc_b(13'd6, 5'd0, 5'd0, 3'b000);
    do_reset();
    repeat (4) @(negedge clk);
    check("misalign.halted",  32'(hlt), 32'd1);
    check("misalign.state",   32'(st),  32'd3);
    check("misalign.pc",      pc,       32'd6);
    check("misalign.retired", 32'(cnt), 32'd1);

    // IMEM_DEPTH=4, RESET_PC=8: run off the end of the ROM
    rom4[2] = enc_r(7'h00, 5'd5, 5'd6, 3'b000, 5'd7);
    rom4[3] = enc_i(12'd1, 5'd1, 3'b000, 5'd1);
    reset4 = 1'b0;
    repeat (2) @(negedge clk);
    reset4 = 1'b1;
    check("d4.reset_pc", pc4, 32'd8);
    repeat (4) @(negedge clk);
    check("d4.pc1",  pc4,             32'd12);
    check("d4.x7",   dut4.r_regs[7],  32'd6011);
    repeat (4) @(negedge clk);
    check("d4.pc2",     pc4,            32'd16);
    check("d4.halted",  32'(hlt4),      32'd1);
    check("d4.state",   32'(st4),       32'd3);
    check("d4.retired", 32'(cnt4),      32'd2);
    check("d4.x1",      dut4.r_regs[1], 32'd3002);
    repeat (4) @(negedge clk);
    check("d4.frozen_pc",  pc4,        32'd16);
    check("d4.frozen_cnt", 32'(cnt4),  32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
